mux_n_1_pipe: RTL

//  Parametrised, pipelined N-to-1 word multiplexer; successor to the flat 32:1 bit mux.
//  Two-stage select tree with valid/ready handshake and pipeline flush.

---
 rtl/mux_n_1_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mux_n_1_pipe.sv
// mux_n_1_pipe: pipelined N-to-1 word multiplexer with valid/ready handshake and flush.
//
// Stage 1 resolves the low select bits inside every group of 2**LO_W inputs and
// registers one word per group, plus the high select bits and an in-range flag.
// Stage 2 resolves the high select bits and registers the final word, which is
// forced to zero for a select >= NUM_INPUTS. Latency is 2 cycles and throughput
// is one word per cycle.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   synchronous reset, active low
//   flush      in   squash both stages; blocks the input for this cycle
//   in_valid   in   select/data_in valid
//   in_ready   out  block accepts this cycle
//   select     in   input index, SEL_W bits
//   data_in    in   input i at [i*WIDTH +: WIDTH]
//   out_valid  out  data_out valid
//   sel_err    out  (only with MUX_SEL_ERR_EN) accepted select was out of range
//   out_ready  in   downstream accepts
//   data_out   out  selected word
//
// Optional feature: define MUX_SEL_ERR_EN to add the sel_err output.

module mux_n_1_pipe #(
    parameter int unsigned NUM_INPUTS = 32,
    parameter int unsigned WIDTH      = 32,
    localparam int unsigned SEL_W     = $clog2(NUM_INPUTS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            select,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    output logic                        out_valid,
`ifdef MUX_SEL_ERR_EN
    output logic                        sel_err,
`endif
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            data_out
);

    localparam int unsigned LO_W       = SEL_W / 2;
    localparam int unsigned HI_W       = SEL_W - LO_W;
    localparam int unsigned NUM_GROUPS = 1 << HI_W;
    localparam int unsigned GROUP_SIZE = 1 << LO_W;
    localparam int unsigned PAD_W      = NUM_GROUPS * GROUP_SIZE * WIDTH;

    // Handshake
    logic s2_ready;
    logic s1_ready;
    logic s1_load;
    logic s2_load;

    // Stage 1 state
    logic                  s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]      s1_word_q [NUM_GROUPS];
    logic [WIDTH-1:0]      s1_word_d [NUM_GROUPS];
    logic [HI_W-1:0]       s1_hi_q, s1_hi_d;
    logic                  s1_ok_q, s1_ok_d;

    // Stage 2 state
    logic                  s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]      data_out_q, data_out_d;
`ifdef MUX_SEL_ERR_EN
    logic                  sel_err_q, sel_err_d;
`endif

    // Stage 1 select tree
    logic [PAD_W-1:0]      data_pad;
    logic [WIDTH-1:0]      grp_word [NUM_GROUPS];
    logic [31:0]           lo_idx;
    logic [HI_W-1:0]       sel_hi;
    logic                  sel_ok;

    // Zero-pad to a full power-of-two input count so unused group slots read 0.
    assign data_pad = PAD_W'(data_in);
    assign sel_hi   = select[SEL_W-1:LO_W];
    assign sel_ok   = (32'(select) < NUM_INPUTS);

    always_comb begin
        // Masking instead of slicing keeps LO_W == 0 legal.
        lo_idx = 32'(select) & (GROUP_SIZE - 1);
        for (int g = 0; g < NUM_GROUPS; g++) begin
            grp_word[g] = data_pad[(g * GROUP_SIZE + lo_idx) * WIDTH +: WIDTH];
        end
    end

    // A stage may load when it is empty or its content leaves this cycle.
    always_comb begin
        s2_ready = ~s2_valid_q | out_ready;
        s1_ready = ~s1_valid_q | s2_ready;
        in_ready = s1_ready & ~flush;
        s1_load  = in_valid & in_ready;
        s2_load  = s1_valid_q & s2_ready & ~flush;
    end

    // Stage 1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_word_d  = s1_word_q;
        s1_hi_d    = s1_hi_q;
        s1_ok_d    = s1_ok_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_ready) begin
            s1_valid_d = in_valid;
        end
        if (s1_load) begin
            s1_word_d = grp_word;
            s1_hi_d   = sel_hi;
            s1_ok_d   = sel_ok;
        end
    end

    // Stage 2 next state
    always_comb begin
        s2_valid_d = s2_valid_q;
        data_out_d = data_out_q;
`ifdef MUX_SEL_ERR_EN
        sel_err_d  = sel_err_q;
`endif
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_ready) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            data_out_d = s1_ok_q ? s1_word_q[s1_hi_q] : '0;
`ifdef MUX_SEL_ERR_EN
            sel_err_d  = ~s1_ok_q;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_word_q  <= '{default: '0};
            s1_hi_q    <= '0;
            s1_ok_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            data_out_q <= '0;
`ifdef MUX_SEL_ERR_EN
            sel_err_q  <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_word_q  <= s1_word_d;
            s1_hi_q    <= s1_hi_d;
            s1_ok_q    <= s1_ok_d;
            s2_valid_q <= s2_valid_d;
            data_out_q <= data_out_d;
`ifdef MUX_SEL_ERR_EN
            sel_err_q  <= sel_err_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign data_out  = data_out_q;
`ifdef MUX_SEL_ERR_EN
    assign sel_err   = sel_err_q;
`endif

endmodule
